// File: rtl/decoder_scan_ctrl.sv
// Scan sequencer for dec3to8: walks sel through the lines with a programmable dwell and a
// one-cycle en=0 gap between lines. Define DECSCAN_SKIP_EN to add the skip_mask line-skip feature.
`timescale 1ns/1ps
module decoder_scan_ctrl #(
  parameter int SEL_W   = 3,
  parameter int DWELL   = 4,
  parameter int DWELL_W = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic                    stop,
  input  logic                    mode_cont,
`ifdef DECSCAN_SKIP_EN
  input  logic [(1<<SEL_W)-1:0]   skip_mask,
`endif
  output logic [SEL_W-1:0]        sel,
  output logic                    en,
  output logic                    busy,
  output logic                    done
);

  localparam int NLINES = 1 << SEL_W;
  localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(DWELL - 1);

  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_GAP} state_e;

  typedef struct packed {
    logic             found;
    logic [SEL_W-1:0] idx;
  } line_t;

  // Lowest unmasked line at or above 'from'; found=0 when none remain.
  function automatic line_t find_line(input logic [NLINES-1:0] mask, input int from);
    line_t res;
    res = '0;
    for (int i = NLINES - 1; i >= 0; i--) begin
      if (i >= from && !mask[i]) begin
        res.found = 1'b1;
        res.idx   = SEL_W'(i);
      end
    end
    return res;
  endfunction

  state_e               state_q, state_d;
  logic [SEL_W-1:0]     sel_q, sel_d;
  logic [DWELL_W-1:0]   cnt_q, cnt_d;
  logic                 mode_q, mode_d;
  logic                 en_q, en_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic [NLINES-1:0]    start_mask;
  logic [NLINES-1:0]    frame_mask;

`ifdef DECSCAN_SKIP_EN
  logic [NLINES-1:0]    mask_q, mask_d;
  assign start_mask = skip_mask;
  assign frame_mask = mask_q;
`else
  assign start_mask = '0;
  assign frame_mask = '0;
`endif

  line_t first_line, wrap_line, next_line;
  logic  dwell_end;

  assign first_line = find_line(start_mask, 0);
  assign wrap_line  = find_line(frame_mask, 0);
  assign next_line  = find_line(frame_mask, int'(sel_q) + 1);
  assign dwell_end  = (cnt_q == DWELL_LAST);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      sel_q   <= '0;
      cnt_q   <= '0;
      mode_q  <= 1'b0;
      en_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef DECSCAN_SKIP_EN
      mask_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
      en_q    <= en_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef DECSCAN_SKIP_EN
      mask_q  <= mask_d;
`endif
    end
  end

  // NOTE: every signal gets a default first so no path through the case infers a latch.
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
`ifdef DECSCAN_SKIP_EN
    mask_d  = mask_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (start && !stop) begin
          mode_d = mode_cont;
`ifdef DECSCAN_SKIP_EN
          mask_d = start_mask;
`endif
          if (first_line.found) begin
            state_d = S_SCAN;
            sel_d   = first_line.idx;
            cnt_d   = '0;
          end
        end
      end
      S_SCAN: begin
        if (stop) begin
          state_d = S_IDLE;
        end else if (dwell_end) begin
          state_d = (next_line.found || mode_q) ? S_GAP : S_IDLE;
        end else begin
          cnt_d = cnt_q + DWELL_W'(1);
        end
      end
      S_GAP: begin
        if (stop) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_SCAN;
          sel_d   = next_line.found ? next_line.idx : wrap_line.idx;
          cnt_d   = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are computed from the next state and registered, keeping inputs off the output paths.
  always_comb begin
    en_d   = (state_d == S_SCAN);
    busy_d = (state_d != S_IDLE);
    done_d = 1'b0;
    if (state_q == S_SCAN && !stop && dwell_end && !next_line.found)
      done_d = 1'b1;
    if (state_q == S_IDLE && start && !stop && !first_line.found)
      done_d = 1'b1;
  end

  assign sel  = sel_q;
  assign en   = en_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_decoder_scan_ctrl.sv
// Directed bench for decoder_scan_ctrl with DWELL=2, SEL_W=3; skip scenarios run when
// DECSCAN_SKIP_EN is defined.
`timescale 1ns/1ps
module tb_decoder_scan_ctrl;

  localparam int SEL_W = 3;
  localparam int DWELL = 2;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic             stop = 1'b0;
  logic             mode_cont = 1'b0;
  logic [SEL_W-1:0] sel;
  logic             en, busy, done;
`ifdef DECSCAN_SKIP_EN
  logic [7:0]       skip_mask = 8'h00;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  decoder_scan_ctrl #(.SEL_W(SEL_W), .DWELL(DWELL), .DWELL_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .stop      (stop),
    .mode_cont (mode_cont),
`ifdef DECSCAN_SKIP_EN
    .skip_mask (skip_mask),
`endif
    .sel       (sel),
    .en        (en),
    .busy      (busy),
    .done      (done)
  );

  // Cycle checker: sel frozen while en stays high, and en never high outside a busy (SCAN) cycle.
  logic             prev_en = 1'b0;
  logic [SEL_W-1:0] prev_sel = '0;
  always @(negedge clk) begin
    if (rst_n) begin
      checks = checks + 1;
      if (en && !busy) begin
        errors = errors + 1;
        $display("FAIL monitor_en_idle t=%0t en=%b busy=%b required en=0 when idle", $time, en, busy);
      end
      checks = checks + 1;
      if (prev_en && en && sel !== prev_sel) begin
        errors = errors + 1;
        $display("FAIL monitor_sel_stable t=%0t sel=%0d required %0d while en=1", $time, sel, prev_sel);
      end
      prev_en  = en;
      prev_sel = sel;
    end else begin
      prev_en = 1'b0;
    end
  end

  function automatic logic [5:0] oneshot_exp(input int c);
    logic [2:0] line;
    line = 3'((c - 1) / 3);
    if (c <= 23) return {line, (c % 3) != 0, 1'b1, 1'b0};
    if (c == 24) return {3'd7, 1'b0, 1'b0, 1'b1};
    return {3'd7, 1'b0, 1'b0, 1'b0};
  endfunction

  task automatic test_reset();
    logic [5:0] got;
    checks = checks + 1;
    got = {sel, en, busy, done};
    if (got !== 6'b0) begin
      errors = errors + 1;
      $display("FAIL reset_initial got=%b required=%b", got, 6'b0);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    start = 1'b1;
    mode_cont = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      start = 1'b0;
    end
    checks = checks + 1;
    got = {sel, en, busy, done};
    if (got !== {3'd3, 1'b1, 1'b1, 1'b0}) begin
      errors = errors + 1;
      $display("FAIL reset_pre_scan got=%b required=%b", got, {3'd3, 1'b1, 1'b1, 1'b0});
    end
    rst_n = 1'b0;
    #1;
    checks = checks + 1;
    got = {sel, en, busy, done};
    if (got !== 6'b0) begin
      errors = errors + 1;
      $display("FAIL reset_mid_scan got=%b required=%b", got, 6'b0);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      checks = checks + 1;
      got = {sel, en, busy, done};
      if (got !== 6'b0) begin
        errors = errors + 1;
        $display("FAIL reset_after c=%0d got=%b required=%b", c, got, 6'b0);
      end
    end
  endtask

  task automatic test_oneshot();
    logic [5:0] got;
    start = 1'b1;
    mode_cont = 1'b0;
    for (int c = 1; c <= 25; c++) begin
      @(negedge clk);
      start = 1'b0;
      checks = checks + 1;
      got = {sel, en, busy, done};
      if (got !== oneshot_exp(c)) begin
        errors = errors + 1;
        $display("FAIL oneshot c=%0d got=%b required=%b", c, got, oneshot_exp(c));
      end
    end
  endtask

  task automatic test_continuous();
    logic [5:0] got, exp;
    int pos;
    start = 1'b1;
    mode_cont = 1'b1;
    for (int c = 1; c <= 64; c++) begin
      @(negedge clk);
      start = 1'b0;
      mode_cont = 1'b0;
      pos = (c - 1) % 24;
      exp = {3'(pos / 3), (pos % 3) != 2, 1'b1, pos == 23};
      checks = checks + 1;
      got = {sel, en, busy, done};
      if (got !== exp) begin
        errors = errors + 1;
        $display("FAIL continuous c=%0d got=%b required=%b", c, got, exp);
      end
    end
    stop = 1'b1;
    for (int c = 65; c <= 67; c++) begin
      @(negedge clk);
      stop = 1'b0;
      checks = checks + 1;
      got = {sel, en, busy, done};
      if (got !== {3'd5, 1'b0, 1'b0, 1'b0}) begin
        errors = errors + 1;
        $display("FAIL continuous_stop c=%0d got=%b required=%b", c, got, {3'd5, 1'b0, 1'b0, 1'b0});
      end
    end
  endtask

  task automatic test_start_held();
    logic [5:0] got;
    start = 1'b1;
    mode_cont = 1'b0;
    for (int c = 1; c <= 24; c++) begin
      @(negedge clk);
      checks = checks + 1;
      got = {sel, en, busy, done};
      if (got !== oneshot_exp(c)) begin
        errors = errors + 1;
        $display("FAIL start_held c=%0d got=%b required=%b", c, got, oneshot_exp(c));
      end
    end
    @(negedge clk);
    checks = checks + 1;
    got = {sel, en, busy, done};
    if (got !== {3'd0, 1'b1, 1'b1, 1'b0}) begin
      errors = errors + 1;
      $display("FAIL start_held_restart got=%b required=%b", got, {3'd0, 1'b1, 1'b1, 1'b0});
    end
    start = 1'b0;
    stop = 1'b1;
    @(negedge clk);
    checks = checks + 1;
    got = {sel, en, busy, done};
    if (got !== 6'b0) begin
      errors = errors + 1;
      $display("FAIL start_held_abort got=%b required=%b", got, 6'b0);
    end
    start = 1'b1;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      checks = checks + 1;
      got = {sel, en, busy, done};
      if (got !== 6'b0) begin
        errors = errors + 1;
        $display("FAIL start_stop_idle c=%0d got=%b required=%b", c, got, 6'b0);
      end
    end
    start = 1'b0;
    stop = 1'b0;
    @(negedge clk);
  endtask

`ifdef DECSCAN_SKIP_EN
  task automatic test_skip();
    logic [5:0] got, exp;
    logic [2:0] lines [4] = '{3'd1, 3'd3, 3'd4, 3'd6};
    skip_mask = 8'b1010_0101;
    start = 1'b1;
    mode_cont = 1'b0;
    for (int c = 1; c <= 13; c++) begin
      @(negedge clk);
      start = 1'b0;
      skip_mask = 8'h00;
      if (c <= 11)      exp = {lines[(c - 1) / 3], (c % 3) != 0, 1'b1, 1'b0};
      else if (c == 12) exp = {3'd6, 1'b0, 1'b0, 1'b1};
      else              exp = {3'd6, 1'b0, 1'b0, 1'b0};
      checks = checks + 1;
      got = {sel, en, busy, done};
      if (got !== exp) begin
        errors = errors + 1;
        $display("FAIL skip c=%0d got=%b required=%b", c, got, exp);
      end
    end
    skip_mask = 8'hFF;
    start = 1'b1;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      start = 1'b0;
      exp = {3'd6, 1'b0, 1'b0, c == 1};
      checks = checks + 1;
      got = {sel, en, busy, done};
      if (got !== exp) begin
        errors = errors + 1;
        $display("FAIL skip_all c=%0d got=%b required=%b", c, got, exp);
      end
    end
    skip_mask = 8'h00;
  endtask
`endif

  initial begin
    #1;
    test_reset();
    test_oneshot();
    test_continuous();
    test_start_held();
`ifdef DECSCAN_SKIP_EN
    test_skip();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
